// File: rtl/mvm_pkg.sv
// mvm_pkg: shared FSM state type, sizing helpers and output conversion
// for the mvm_pipe_param matrix-vector multiplier.
package mvm_pkg;

    typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_A, COMPUTE, DRAIN, OUTPUT} state_t;

    function automatic int accw(input int iw, input int n);
        return 2 * iw + $clog2(n);
    endfunction

    function automatic int chunks(input int n, input int p);
        return n / p;
    endfunction

    function automatic int cw(input int v);
        return v < 2 ? 1 : $clog2(v);
    endfunction

    // Callers truncate the result to the output width; with sat set the value is clamped first.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] v, input int ow, input bit sat);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        return !sat ? v : (v > hi ? hi : (v < lo ? lo : v));
    endfunction

endpackage

// File: rtl/mvm_lane_tree.sv
// mvm_lane_tree: P registered signed multipliers feeding a combinational
// log2(P)-level adder tree, padded with zero leaves up to a power of two.
module mvm_lane_tree #(
    parameter int P    = 4,
    parameter int IW   = 8,
    parameter int ACCW = 18
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [P-1:0][IW-1:0]   a,
    input  logic [P-1:0][IW-1:0]   x,
    output logic signed [ACCW-1:0] sum
);
    localparam int LV = $clog2(P);
    localparam int P2 = 1 << LV;

    logic signed [2*IW-1:0] prod [P];

    always_ff @(posedge clk or posedge reset)
        if (reset)
            for (int j = 0; j < P; j++) prod[j] <= '0;
        else
            for (int j = 0; j < P; j++) prod[j] <= (2*IW)'($signed(a[j])) * (2*IW)'($signed(x[j]));

    genvar l, i;
    for (l = 0; l <= LV; l++) begin : g_lvl
        logic signed [ACCW-1:0] v [P2 >> l];
        for (i = 0; i < (P2 >> l); i++) begin : g_n
            if (l == 0) begin : g_leaf
                if (i < P) begin : g_p
                    assign v[i] = ACCW'(prod[i]);
                end else begin : g_z
                    assign v[i] = '0;
                end
            end else begin : g_add
                assign v[i] = g_lvl[l-1].v[2*i] + g_lvl[l-1].v[2*i+1];
            end
        end
    end

    assign sum = g_lvl[LV].v[0];

endmodule

// File: rtl/mvm_pipe_param.sv
// mvm_pipe_param: streaming N x N signed matrix-vector multiplier, y = A*x,
// with P MAC lanes, a three-stage issue/multiply/accumulate pipeline and serial output.
module mvm_pipe_param
    import mvm_pkg::*;
#(
    parameter int N   = 4,
    parameter int P   = 4,
    parameter int IW  = 8,
    parameter int OW  = 16,
    parameter int SAT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic signed [IW-1:0] data_in,
    output logic                 ready,
    output logic signed [OW-1:0] data_out,
    output logic                 out_valid,
    output logic                 done
);
    localparam int ACCW = accw(IW, N);
    localparam int CH   = chunks(N, P);
    localparam int CW   = cw(N * N);
    localparam int RW   = cw(N);
    localparam int KW   = cw(CH);

    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [RW-1:0] row, s1_row, s2_row;
    logic [KW-1:0] chk;
    logic chk_last, row_last, issue;
    logic s1_v, s1_first, s1_last, s2_v, s2_first, s2_last;
    logic [P-1:0][IW-1:0] s1_a, s1_x;
    logic signed [ACCW-1:0] sum, acc, acc_nxt;
    logic signed [OW-1:0] dq;
    logic signed [IW-1:0] x_mem [N];
    logic signed [IW-1:0] a_mem [N*N];
    logic signed [OW-1:0] y_mem [N];

    assign chk_last = chk == KW'(CH - 1);
    assign row_last = row == RW'(N - 1);
    assign issue    = state == COMPUTE;
    assign acc_nxt  = s2_first ? sum : acc + sum;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? LOAD_X : IDLE;
            LOAD_X:  state_nxt = cnt == CW'(N - 1) ? LOAD_A : LOAD_X;
            LOAD_A:  state_nxt = cnt == CW'(N * N - 1) ? COMPUTE : LOAD_A;
            COMPUTE: state_nxt = row_last && chk_last ? DRAIN : COMPUTE;
            DRAIN:   state_nxt = !s1_v && !s2_v ? OUTPUT : DRAIN;
            OUTPUT:  state_nxt = cnt == CW'(N - 1) ? IDLE : OUTPUT;
            default: state_nxt = IDLE;
        endcase
    end

    // dq holds the last emitted element so data_out stays stable once OUTPUT ends.
    always_comb begin
        ready     = state == IDLE;
        out_valid = state == OUTPUT;
        done      = out_valid && cnt == CW'(N - 1);
        data_out  = out_valid ? y_mem[RW'(cnt)] : dq;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            row      <= '0;
            chk      <= '0;
            s1_v     <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_row   <= '0;
            s2_v     <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_row   <= '0;
            acc      <= '0;
            dq       <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= state_nxt != state ? '0 : cnt + 1'b1;
            chk      <= issue && !chk_last ? chk + 1'b1 : '0;
            row      <= issue ? row + RW'(chk_last) : '0;
            s1_v     <= issue;
            s1_first <= chk == '0;
            s1_last  <= chk_last;
            s1_row   <= row;
            s2_v     <= s1_v;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_row   <= s1_row;
            acc      <= s2_v ? acc_nxt : acc;
            dq       <= out_valid ? data_out : dq;
        end

    // Chunks issue in row-major order, so the issue index times P is the A address.
    always_ff @(posedge clk) begin
        if (state == LOAD_X) x_mem[RW'(cnt)] <= data_in;
        if (state == LOAD_A) a_mem[cnt] <= data_in;
        if (s2_v && s2_last) y_mem[s2_row] <= OW'(sat_trunc(64'(acc_nxt), OW, SAT != 0));
        for (int l = 0; l < P; l++) begin
            s1_a[l] <= a_mem[CW'(int'(cnt) * P + l)];
            s1_x[l] <= x_mem[RW'(int'(chk) * P + l)];
        end
    end

    mvm_lane_tree #(.P(P), .IW(IW), .ACCW(ACCW)) u_tree (
        .clk   (clk),
        .reset (reset),
        .a     (s1_a),
        .x     (s1_x),
        .sum   (sum)
    );

endmodule

// File: tb/tb_mvm_pipe_param.sv
// tb_mvm_pipe_param: scoreboard bench for three N=4 instances
// (P=4 wrap, P=2 wrap, P=4 saturate) against a plain arithmetic model.
module tb_mvm_pipe_param;

    typedef struct {int d; int y; int cyc; bit last;} exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic st [3];
    logic signed [7:0] din [3];
    logic rdy [3], ov [3], dn [3];
    logic signed [15:0] dout [3];
    int cyc = 0, nchk = 0, nfail = 0;
    int xv [4];
    int av [16];
    exp_t q [$];
    exp_t e;
    logic prev_done [3];
    int last_val [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mvm_pipe_param #(.N(4), .P(4), .IW(8), .OW(16), .SAT(0)) dut0 (
        .clk(clk), .reset(reset), .start(st[0]), .data_in(din[0]),
        .ready(rdy[0]), .data_out(dout[0]), .out_valid(ov[0]), .done(dn[0]));
    mvm_pipe_param #(.N(4), .P(2), .IW(8), .OW(16), .SAT(0)) dut1 (
        .clk(clk), .reset(reset), .start(st[1]), .data_in(din[1]),
        .ready(rdy[1]), .data_out(dout[1]), .out_valid(ov[1]), .done(dn[1]));
    mvm_pipe_param #(.N(4), .P(4), .IW(8), .OW(16), .SAT(1)) dut2 (
        .clk(clk), .reset(reset), .start(st[2]), .data_in(din[2]),
        .ready(rdy[2]), .data_out(dout[2]), .out_valid(ov[2]), .done(dn[2]));

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int conv(input int v, input bit sat);
        if (sat) return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
        return ((v + 32768) % 65536 + 65536) % 65536 - 32768;
    endfunction

    task automatic ramp(input int b);
        for (int i = 0; i < 4; i++) xv[i] = b + i;
        for (int i = 0; i < 16; i++) av[i] = b + 4 + i;
    endtask

    task automatic fill(input int xval, input int aval);
        for (int i = 0; i < 4; i++) xv[i] = xval;
        for (int i = 0; i < 16; i++) av[i] = aval;
    endtask

    task automatic rnd();
        for (int i = 0; i < 4; i++) xv[i] = int'($urandom_range(255)) - 128;
        for (int i = 0; i < 16; i++) av[i] = int'($urandom_range(255)) - 128;
    endtask

    // Start, stream x then A; optionally poke start mid-load; push expected y after last A.
    task automatic job(input int d, input bit push, input bit poke);
        int l, v, c;
        exp_t t;
        c = d == 1 ? 8 : 4;
        @(posedge clk); #1 st[d] = 1'b1;
        @(posedge clk); #1 st[d] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            din[d] = 8'(i < 4 ? xv[i] : av[i-4]);
            if (poke) st[d] = i == 10;
            @(posedge clk); #1;
        end
        st[d] = 1'b0;
        l = cyc;
        if (push)
            for (int r = 0; r < 4; r++) begin
                v = 0;
                for (int k = 0; k < 4; k++) v += av[4*r+k] * xv[k];
                t.d = d; t.y = conv(v, d == 2); t.cyc = l + c + 3 + r; t.last = r == 3;
                q.push_back(t);
            end
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!dn[d] && n < 300);
        chk($sformatf("done_seen_dut%0d", d), dn[d], 1);
    endtask

    task automatic wait_valid(input int d);
        int n = 0;
        while (!ov[d] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("valid_seen_dut%0d", d), ov[d], 1);
    endtask

    always @(negedge clk)
        for (int d = 0; d < 3; d++)
            if (reset) prev_done[d] = 1'b0;
            else begin
                if (prev_done[d]) begin
                    chk($sformatf("post_ready_dut%0d", d), rdy[d], 1);
                    chk($sformatf("post_valid_dut%0d", d), ov[d], 0);
                    chk($sformatf("post_hold_dut%0d", d), dout[d], last_val[d]);
                end
                if (ov[d]) begin
                    if (q.size() == 0) begin
                        nchk++; nfail++;
                        $display("FAIL unexpected_out dut%0d: got %0d expected no output", d, dout[d]);
                    end else begin
                        e = q.pop_front();
                        chk("out_dut", d, e.d);
                        chk($sformatf("y_dut%0d", d), dout[d], e.y);
                        chk($sformatf("latency_dut%0d", d), cyc, e.cyc);
                        chk($sformatf("done_flag_dut%0d", d), dn[d], e.last);
                    end
                    last_val[d] = dout[d];
                end else if (dn[d]) begin
                    nchk++; nfail++;
                    $display("FAIL spurious_done dut%0d: got done=1 expected done=0 without out_valid", d);
                end
                prev_done[d] = dn[d] && ov[d];
            end

    initial begin
        for (int d = 0; d < 3; d++) begin
            st[d] = 1'b0;
            din[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", rdy[d], 1);
            chk("rst_valid", ov[d], 0);
            chk("rst_data", dout[d], 0);
            chk("rst_done", dn[d], 0);
        end
        reset = 1'b0;
        ramp(0);  job(0, 1, 0); wait_done(0);
        ramp(10); job(0, 1, 0); wait_done(0);
        ramp(0);  job(0, 1, 1);
        wait_valid(0);
        st[0] = 1'b1;
        @(posedge clk); #1 st[0] = 1'b0;
        wait_done(0);
        repeat (30) @(posedge clk);
        ramp(0);  job(1, 1, 0); wait_done(1);
        fill(-128, -128); job(0, 1, 0); wait_done(0);
        job(2, 1, 0); wait_done(2);
        fill(127, -128);  job(2, 1, 0); wait_done(2);
        job(0, 1, 0); wait_done(0);
        for (int d = 0; d < 3; d++)
            for (int n = 0; n < 3; n++) begin
                rnd();
                job(d, 1, 0);
                wait_done(d);
            end
        ramp(0); job(0, 0, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("midrst_ready", rdy[0], 1);
        chk("midrst_valid", ov[0], 0);
        chk("midrst_data", dout[0], 0);
        chk("midrst_done", dn[0], 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        ramp(0); job(0, 1, 0); wait_done(0);
        repeat (40) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
